// File: rtl/vregfile_pkg.sv
// Shared definitions for the vector register file.
// Holds the SEW encoding, the element-size helper and the write-mask
// expansion that turns a per-element mask into per-byte enables.
package vregfile_pkg;

   typedef enum logic [1:0] {
      SEW8  = 2'd0,
      SEW16 = 2'd1,
      SEW32 = 2'd2,
      SEW64 = 2'd3
   } sew_e;

   // Upper bound on VLEN/8. This sets the width the helper works at.
   // Callers truncate the result to their own byte count.
   localparam int MAXB = 256;

   // Element size in bytes for a given SEW code.
   function automatic int sew_bytes(input logic [1:0] sew);
      return 1 << sew;
   endfunction

   // Byte b belongs to element b >> sew, so its enable is that element's mask bit.
   // Mask bits past VLEN/SEW are never indexed by any in-range byte.
   // For that reason they have no effect.
   function automatic logic [MAXB-1:0] expand_mask(input logic [MAXB-1:0] wmask,
                                                   input logic [1:0]      sew);
      logic [MAXB-1:0] be;
      be = '0;
      for (int b = 0; b < MAXB; b++) begin
         be[b] = wmask[b >> sew];
      end
      return be;
   endfunction

endpackage

// File: rtl/vector_registerfile_if.sv
// Bus between decode/writeback (master) and the vector register file (slave).
// Carries the write port (RegWrite/rd/wdata/sew/wmask), the three read ports,
// v0 as vmask, the reserve request and the scoreboard outputs.
interface vector_registerfile_if #(
   parameter int VLEN = 128,
   parameter int NREG = 32,
   localparam int AW  = $clog2(NREG)
);
   logic              RegWrite;
   logic [AW-1:0]     rd;
   logic [VLEN-1:0]   wdata;
   logic [1:0]        sew;
   logic [VLEN/8-1:0] wmask;
   logic [AW-1:0]     rs1, rs2, rs3;
   logic [VLEN-1:0]   rdata1, rdata2, rdata3;
   logic [VLEN-1:0]   vmask;
   logic              rsv_valid;
   logic [AW-1:0]     rsv_addr;
   logic              busy1, busy2, busy3;
   logic              rsv_conflict;

   modport master (
      output RegWrite, rd, wdata, sew, wmask, rs1, rs2, rs3, rsv_valid, rsv_addr,
      input  rdata1, rdata2, rdata3, vmask, busy1, busy2, busy3, rsv_conflict
   );

   modport slave (
      input  RegWrite, rd, wdata, sew, wmask, rs1, rs2, rs3, rsv_valid, rsv_addr,
      output rdata1, rdata2, rdata3, vmask, busy1, busy2, busy3, rsv_conflict
   );
endinterface

// File: rtl/vreg_scoreboard.sv
// Per-register pending bits for multi-cycle vector ops.
// Ports:
//   clk, rst (async active-high)
//   we, rd            : writeback clears pending[rd]
//   rsv_valid/addr    : issue sets pending[rsv_addr]
//   rs1..rs3          : lookup addresses
//   busy1..busy3      : pending state of rs1..rs3 (from state, not bypassed)
//   rsv_conflict      : registered pulse, reserve hit an already-pending register
module vreg_scoreboard #(
   parameter int NREG = 32,
   localparam int AW  = $clog2(NREG)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          we,
   input  logic [AW-1:0] rd,
   input  logic          rsv_valid,
   input  logic [AW-1:0] rsv_addr,
   input  logic [AW-1:0] rs1,
   input  logic [AW-1:0] rs2,
   input  logic [AW-1:0] rs3,
   output logic          busy1,
   output logic          busy2,
   output logic          busy3,
   output logic          rsv_conflict
);
   logic [NREG-1:0] pending;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pending      <= '0;
         rsv_conflict <= 1'b0;
      end else begin
         // A reserve on the register being retired means a new producer was issued.
         // In that case the set takes priority over the clear.
         for (int i = 0; i < NREG; i++) begin
            if (rsv_valid && rsv_addr == AW'(i))
               pending[i] <= 1'b1;
            else if (we && rd == AW'(i))
               pending[i] <= 1'b0;
         end
         rsv_conflict <= rsv_valid & pending[rsv_addr] & ~(we & (rd == rsv_addr));
      end
   end

   assign busy1 = pending[rs1];
   assign busy2 = pending[rs2];
   assign busy3 = pending[rs3];
endmodule

// File: rtl/vector_registerfile.sv
// Vector register file: NREG x VLEN storage, three combinational read ports,
// one SEW-masked write port, optional write-to-read bypass, pending scoreboard.
// Ports:
//   clk, rst : clock and async active-high reset
//   bus      : vector_registerfile_if slave (write port, read ports, vmask=v0,
//              reserve request, busy lookups, rsv_conflict)
module vector_registerfile
   import vregfile_pkg::*;
#(
   parameter int VLEN   = 128,
   parameter int NREG   = 32,
   parameter int BYPASS = 1,
   localparam int AW    = $clog2(NREG),
   localparam int VB    = VLEN / 8
) (
   input  logic                  clk,
   input  logic                  rst,
   vector_registerfile_if.slave  bus
);
   logic [VLEN-1:0] regs [NREG];
   logic [VB-1:0]   be;
   logic [VLEN-1:0] merged;

   // Write data merged over the current contents of rd.
   // The merge is byte by byte, using the expanded byte enables.
   always_comb begin
      be     = VB'(expand_mask(MAXB'(bus.wmask), bus.sew));
      merged = regs[bus.rd];
      for (int b = 0; b < VB; b++) begin
         if (be[b]) merged[b*8 +: 8] = bus.wdata[b*8 +: 8];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NREG; i++) regs[i] <= '0;
      end else if (bus.RegWrite) begin
         regs[bus.rd] <= merged;
      end
   end

   function automatic logic [VLEN-1:0] read_port(input logic [AW-1:0] a);
      if (BYPASS != 0 && bus.RegWrite && a == bus.rd) return merged;
      return regs[a];
   endfunction

   always_comb begin
      bus.rdata1 = read_port(bus.rs1);
      bus.rdata2 = read_port(bus.rs2);
      bus.rdata3 = read_port(bus.rs3);
      bus.vmask  = read_port('0);
   end

   vreg_scoreboard #(.NREG(NREG)) u_sb (
      .clk          (clk),
      .rst          (rst),
      .we           (bus.RegWrite),
      .rd           (bus.rd),
      .rsv_valid    (bus.rsv_valid),
      .rsv_addr     (bus.rsv_addr),
      .rs1          (bus.rs1),
      .rs2          (bus.rs2),
      .rs3          (bus.rs3),
      .busy1        (bus.busy1),
      .busy2        (bus.busy2),
      .busy3        (bus.busy3),
      .rsv_conflict (bus.rsv_conflict)
   );
endmodule

// File: tb/tb_vector_registerfile.sv
// Directed bench for vector_registerfile: a BYPASS=1 and a BYPASS=0 instance
// driven with identical stimulus, a table of masked-write vectors, and
// hand-written sequences for reset, bypass, scoreboard and v0.
module tb_vector_registerfile;
   localparam int VLEN = 128;
   localparam int NREG = 32;
   localparam int VB   = VLEN / 8;

   logic clk;
   logic rst;
   int   n_cmp;
   int   n_bad;

   vector_registerfile_if #(.VLEN(VLEN), .NREG(NREG)) if1 ();
   vector_registerfile_if #(.VLEN(VLEN), .NREG(NREG)) if0 ();

   vector_registerfile #(.VLEN(VLEN), .NREG(NREG), .BYPASS(1)) dut1 (
      .clk (clk), .rst (rst), .bus (if1.slave));
   vector_registerfile #(.VLEN(VLEN), .NREG(NREG), .BYPASS(0)) dut0 (
      .clk (clk), .rst (rst), .bus (if0.slave));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [4:0]      rd;
      logic [VLEN-1:0] initv;
      logic [1:0]      sew;
      logic [VB-1:0]   wmask;
      logic [VLEN-1:0] wdata;
      logic [VLEN-1:0] exp;
   } vec_t;

   vec_t tbl [8];

   task automatic check(input string name, input logic [VLEN-1:0] got, input logic [VLEN-1:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   task automatic set_wr(input logic we, input logic [4:0] rd, input logic [1:0] sew,
                         input logic [VB-1:0] wm, input logic [VLEN-1:0] wd);
      if1.RegWrite = we; if1.rd = rd; if1.sew = sew; if1.wmask = wm; if1.wdata = wd;
      if0.RegWrite = we; if0.rd = rd; if0.sew = sew; if0.wmask = wm; if0.wdata = wd;
   endtask

   task automatic set_rs(input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] a3);
      if1.rs1 = a1; if1.rs2 = a2; if1.rs3 = a3;
      if0.rs1 = a1; if0.rs2 = a2; if0.rs3 = a3;
   endtask

   task automatic set_rsv(input logic v, input logic [4:0] a);
      if1.rsv_valid = v; if1.rsv_addr = a;
      if0.rsv_valid = v; if0.rsv_addr = a;
   endtask

   // Advance to just after the next rising edge; inputs change here.
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;
      rst   = 1'b0;
      set_wr(1'b0, 5'd0, 2'd0, '0, '0);
      set_rs(5'd1, 5'd2, 5'd3);
      set_rsv(1'b0, 5'd0);

      tbl[0] = '{5'd3,  '0, 2'd2, 16'h0005,
                 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA,
                 128'h00000000_CCCCCCCC_00000000_AAAAAAAA};
      tbl[1] = '{5'd4,  '0, 2'd0, 16'h0001, {VLEN{1'b1}}, 128'hFF};
      tbl[2] = '{5'd4,  '0, 2'd3, 16'h0002, {VLEN{1'b1}},
                 128'hFFFFFFFF_FFFFFFFF_00000000_00000000};
      tbl[3] = '{5'd6,  '0, 2'd1, 16'h00AA, {VLEN{1'b1}},
                 128'hFFFF0000_FFFF0000_FFFF0000_FFFF0000};
      tbl[4] = '{5'd8,  {32{4'h1}}, 2'd3, 16'hFFFC, '0, {32{4'h1}}};
      tbl[5] = '{5'd9,  {32{4'h5}}, 2'd2, 16'h0000, '0, {32{4'h5}}};
      tbl[6] = '{5'd10, '0, 2'd0, 16'hFFFF,
                 128'h01234567_89ABCDEF_FEDCBA98_76543210,
                 128'h01234567_89ABCDEF_FEDCBA98_76543210};
      tbl[7] = '{5'd11, {VLEN{1'b1}}, 2'd0, 16'h8001, '0,
                 128'h00FFFFFF_FFFFFFFF_FFFFFFFF_FFFFFF00};

      // Reset behaviour
      #1 rst = 1'b1;
      #1;
      check("rst_rdata1", if1.rdata1, '0);
      check("rst_vmask", if1.vmask, '0);
      check("rst_busy", {125'd0, if1.busy1, if1.busy2, if1.busy3}, '0);
      check("rst_conflict", {127'd0, if1.rsv_conflict}, '0);
      tick();
      rst = 1'b0;
      tick();
      set_wr(1'b1, 5'd1, 2'd0, '1, {VLEN{1'b1}});
      set_rsv(1'b1, 5'd1);
      set_rs(5'd1, 5'd1, 5'd1);
      tick();
      set_wr(1'b0, 5'd0, 2'd0, '0, '0);
      set_rsv(1'b0, 5'd0);
      #1;
      check("pre_rst_v1", if1.rdata1, {VLEN{1'b1}});
      check("pre_rst_busy1", {127'd0, if1.busy1}, 128'd1);
      rst = 1'b1;
      #1;
      check("midrst_rdata1", if1.rdata1, '0);
      check("midrst_busy", {125'd0, if1.busy1, if1.busy2, if1.busy3}, '0);
      set_wr(1'b1, 5'd1, 2'd0, '1, {VLEN{1'b1}});
      tick();
      set_wr(1'b0, 5'd0, 2'd0, '0, '0);
      #1;
      check("rst_held_v1", if0.rdata1, '0);
      rst = 1'b0;
      tick();
      #1;
      check("post_rst_v1", if1.rdata1, '0);

      // Masked write table
      for (int i = 0; i < 8; i++) begin
         set_wr(1'b1, tbl[i].rd, 2'd0, '1, tbl[i].initv);
         tick();
         set_wr(1'b1, tbl[i].rd, tbl[i].sew, tbl[i].wmask, tbl[i].wdata);
         tick();
         set_wr(1'b0, 5'd0, 2'd0, '0, '0);
         set_rs(tbl[i].rd, 5'd0, 5'd0);
         #1;
         check($sformatf("vec%0d_byp", i), if1.rdata1, tbl[i].exp);
         check($sformatf("vec%0d_nobyp", i), if0.rdata1, tbl[i].exp);
      end

      // Bypass: full and partial merge against an older value
      set_wr(1'b1, 5'd5, 2'd0, '1, {32{4'hA}});
      tick();
      set_rs(5'd5, 5'd5, 5'd5);
      set_wr(1'b1, 5'd5, 2'd0, 16'hFFFF, 128'h1234);
      #1;
      check("byp1_rdata1", if1.rdata1, 128'h1234);
      check("byp0_rdata1", if0.rdata1, {32{4'hA}});
      tick();
      set_wr(1'b1, 5'd5, 2'd0, 16'h0001, 128'hFF);
      #1;
      check("byp0_after_edge", if0.rdata1, 128'h1234);
      check("byp1_merge_rdata2", if1.rdata2, 128'h12FF);
      check("byp0_merge_rdata3", if0.rdata3, 128'h1234);
      tick();
      set_wr(1'b0, 5'd0, 2'd0, '0, '0);
      #1;
      check("byp_stored", if0.rdata2, 128'h12FF);

      // Scoreboard
      set_rs(5'd7, 5'd7, 5'd12);
      set_rsv(1'b1, 5'd7);
      #1;
      check("sb_busy_same_cycle", {127'd0, if1.busy1}, '0);
      tick();
      set_rsv(1'b0, 5'd0);
      #1;
      check("sb_busy_after_rsv", {126'd0, if1.busy1, if1.busy2}, 128'd3);
      check("sb_no_conflict", {127'd0, if1.rsv_conflict}, '0);
      set_rsv(1'b1, 5'd7);
      tick();
      set_rsv(1'b0, 5'd0);
      #1;
      check("sb_conflict_pulse", {127'd0, if1.rsv_conflict}, 128'd1);
      tick();
      #1;
      check("sb_conflict_drop", {127'd0, if1.rsv_conflict}, '0);
      set_wr(1'b1, 5'd7, 2'd0, '1, 128'h77);
      #1;
      check("sb_busy_before_clear", {127'd0, if1.busy1}, 128'd1);
      tick();
      set_wr(1'b0, 5'd0, 2'd0, '0, '0);
      #1;
      check("sb_cleared", {127'd0, if1.busy1}, '0);
      set_wr(1'b1, 5'd7, 2'd0, '1, 128'h78);
      set_rsv(1'b1, 5'd7);
      tick();
      #1;
      check("sb_set_wins", {127'd0, if1.busy1}, 128'd1);
      check("sb_set_wins_noconf", {127'd0, if1.rsv_conflict}, '0);
      tick();
      set_wr(1'b0, 5'd0, 2'd0, '0, '0);
      #1;
      check("sb_pend_rsvwr_noconf", {127'd0, if1.rsv_conflict}, '0);
      check("sb_still_busy", {127'd0, if1.busy1}, 128'd1);
      set_wr(1'b1, 5'd7, 2'd0, '1, 128'h79);
      set_rsv(1'b1, 5'd12);
      tick();
      set_wr(1'b0, 5'd0, 2'd0, '0, '0);
      set_rsv(1'b0, 5'd0);
      #1;
      check("sb_diff_regs", {126'd0, if1.busy1, if1.busy3}, 128'd1);
      check("sb_diff_noconf", {127'd0, if1.rsv_conflict}, '0);

      // v0 drives vmask
      set_wr(1'b1, 5'd0, 2'd0, '1, {16{8'hF0}});
      #1;
      check("v0_byp1", if1.vmask, {16{8'hF0}});
      check("v0_byp0_old", if0.vmask, '0);
      tick();
      set_wr(1'b0, 5'd0, 2'd0, '0, '0);
      #1;
      check("v0_stored", if0.vmask, {16{8'hF0}});

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/vector_registerfile.md
# vector_registerfile

Parametrised vector register file for the V-extension datapath: NREG registers of VLEN bits with three asynchronous read ports, one write port with element-granularity masking selected by SEW, optional same-cycle write-to-read bypass, and a per-register pending scoreboard for multi-cycle vector ops. Sits beside the scalar Registerfile; decode reads it and reserves destinations at issue, and the vector writeback stage writes it.

## Interface
- VLEN, 128: register width in bits; power of two, ≥64.
- NREG, 32: register count; power of two.
- BYPASS, 1: 1 = read of the register being written this cycle returns the merged new value.
- AW: derived localparam, log2(NREG).
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- RegWrite  in  1  write enable.
- rd  in  AW  write address.
- wdata  in  VLEN  write data.
- sew  in  2  element width: 0=8, 1=16, 2=32, 3=64 bits.
- wmask  in  VLEN/8  element write mask; bit i enables element i at current sew; bits ≥ VLEN/SEW ignored.
- rs1, rs2, rs3  in  AW  read addresses (rs3 = old vd for merge/accumulate).
- rdata1, rdata2, rdata3  out  VLEN  read data.
- vmask  out  VLEN  always contents of v0.
- rsv_valid  in  1  reserve request: mark rsv_addr pending.
- rsv_addr  in  AW  register to reserve.
- busy1, busy2, busy3  out  1  pending bit of rs1/rs2/rs3.
- rsv_conflict  out  1  registered; pulses one cycle after a reserve to an already-pending register.

## Operation
- Storage: NREG × VLEN flops; pending: NREG bits.
- Write mask expansion: element i spans bits [i·SEW +: SEW]; byte enable b = wmask[b >> sew] (b = byte index 0..VLEN/8-1). Disabled bytes keep old value.
- Write commits at posedge when RegWrite=1; all-zero effective mask = no data change, pending still cleared.
- Reads combinational from storage. BYPASS=1 and RegWrite=1 and rsN==rd: rdataN = merged (old/wdata by byte enable). BYPASS=0: old value until the edge. Same for vmask when rd==0.
- Scoreboard: rsv_valid sets pending[rsv_addr]; RegWrite clears pending[rd]. Same register, same cycle: set wins (new producer issued). Different registers: both apply.
- busyN = pending[rsN] from state (not bypassed against same-cycle clear/set).
- rsv_conflict <= rsv_valid & pending[rsv_addr] & ~(RegWrite & rd==rsv_addr).
- No hardwired-zero register; v0 is ordinary storage.

## Timing
- Reset (asserted, asynchronous): all registers 0, all pending 0, rsv_conflict 0; therefore rdata*, vmask, busy* read 0 immediately.
- Reset mid-operation: in-flight write on that edge discarded; state held at 0 while rst=1; first write accepted on first rising edge with rst=0.
- Write latency: 1 edge to storage; 0 cycles to read ports when BYPASS=1.
- Reserve: busy visible the cycle after rsv_valid. Clear: busy drops the cycle after the write.
- rsv_conflict: one-cycle pulse, cycle after the offending request.

## Structure
- Shared package vregfile_pkg: sew encoding constants (SEW8..SEW64), function sew_bytes(sew), function expand_mask(wmask, sew) → VLEN/8 byte enables.
- One sub-module: vreg_scoreboard (pending bits, reserve/clear priority, busy lookup, conflict flag). Storage, masking, bypass in top.

## Test plan
- Reset: write v1=all-ones, assert rst mid-cycle -> rdata1=0, busy*=0 immediately; after release read v1=0.
- Masked write sew=2 (32b), VLEN=128: v3=0, write wdata=0xDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA, wmask=0b0101 -> v3=0x00000000_CCCCCCCC_00000000_AAAAAAAA.
- Mask width by sew: sew=0, wmask=0x0001 on v4=0 with wdata all 0xFF -> only byte 0 = 0xFF; sew=3, wmask=0x0002 -> upper 64 bits written.
- Bypass: BYPASS=1, RegWrite with rd=rs1=5, wdata=0x1234 full mask -> rdata1=0x1234 same cycle; BYPASS=0 -> old value until edge.
- Scoreboard: reserve v7 -> busy1 (rs1=7)=1 next cycle; write v7 -> busy1=0 next cycle; reserve and write v7 same cycle -> busy stays 1, rsv_conflict=1 only if v7 was already pending without that write.
- v0: write v0=0xF0F0… full mask -> vmask updates same cycle (BYPASS=1), stored after edge.
